// File: rtl/clz_pkg.sv
// rtl/clz_pkg.sv - shared constants and mode encoding for the leading-bit counter
package clz_pkg;

  localparam int CLZ_WIDTH  = 32;
  localparam int CLZ_CNT_W  = 6;
  localparam int CLZ_LEAF_W = 4;

  typedef enum logic {
    CLZ_MODE_ZERO = 1'b0,
    CLZ_MODE_ONE  = 1'b1
  } clz_mode_e;

endpackage

// File: rtl/clz_enc_node.sv
// rtl/clz_enc_node.sv - one node of the leading-zero encoder tree (4-bit leaf or merge of two halves)
module clz_enc_node
  import clz_pkg::*;
#(
  parameter bit LEAF   = 1'b1,
  parameter int CW_OUT = 2
) (
  input  logic [2*CW_OUT-1:0] pair_i,
  output logic                any_o,
  output logic [CW_OUT-1:0]   cnt_o
);

  // Leaf: pair_i is the raw nibble. Merge: pair_i = {hi_any, hi_cnt, lo_any, lo_cnt}.
  if (LEAF) begin : g_leaf
    assign any_o = |pair_i;
    assign cnt_o = {~(pair_i[3] | pair_i[2]), ~pair_i[3] & (pair_i[2] | ~pair_i[1])};
  end else begin : g_merge
    logic              hi_any;
    logic              lo_any;
    logic [CW_OUT-2:0] hi_cnt;
    logic [CW_OUT-2:0] lo_cnt;

    assign hi_any = pair_i[2*CW_OUT-1];
    assign hi_cnt = pair_i[2*CW_OUT-2 -: CW_OUT-1];
    assign lo_any = pair_i[CW_OUT-1];
    assign lo_cnt = pair_i[CW_OUT-2:0];

    assign any_o = hi_any | lo_any;
    assign cnt_o = hi_any ? {1'b0, hi_cnt} : {1'b1, lo_cnt};
  end

endmodule

// File: rtl/clz_counter.sv
// rtl/clz_counter.sv - registered CLZ/CLO unit built from a balanced encoder tree
module clz_counter
  import clz_pkg::*;
#(
  parameter int WIDTH = CLZ_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             clo,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] num,
  output logic             all_zero,
  output logic             out_valid
);

  localparam int LOG2W  = $clog2(WIDTH);
  localparam int LEAF_D = LOG2W - $clog2(CLZ_LEAF_W);

  logic [WIDTH-1:0] x;
  logic             root_any;
  logic [LOG2W-1:0] root_cnt;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] num_q, num_d;
  logic             all_zero_q, all_zero_d;
  logic             valid_q, valid_d;

  assign x = (clz_mode_e'(clo) == CLZ_MODE_ONE) ? ~data : data;

  // Level d holds 2^d nodes; node j of level d combines nodes 2j (upper) and 2j+1 of level d+1.
  for (genvar d = 0; d <= LEAF_D; d++) begin : g_lvl
    localparam int NN = 1 << d;
    localparam int CW = LOG2W - d;

    logic [NN-1:0] any_v;
    logic [CW-1:0] cnt_v [NN];

    for (genvar j = 0; j < NN; j++) begin : g_node
      if (d == LEAF_D) begin : g_leaf
        clz_enc_node #(
          .LEAF   (1'b1),
          .CW_OUT (2)
        ) u_node (
          .pair_i (x[WIDTH-1-CLZ_LEAF_W*j -: CLZ_LEAF_W]),
          .any_o  (any_v[j]),
          .cnt_o  (cnt_v[j])
        );
      end else begin : g_merge
        clz_enc_node #(
          .LEAF   (1'b0),
          .CW_OUT (CW)
        ) u_node (
          .pair_i ({g_lvl[d+1].any_v[2*j],   g_lvl[d+1].cnt_v[2*j],
                    g_lvl[d+1].any_v[2*j+1], g_lvl[d+1].cnt_v[2*j+1]}),
          .any_o  (any_v[j]),
          .cnt_o  (cnt_v[j])
        );
      end
    end
  end

  assign root_any = g_lvl[0].any_v[0];
  assign root_cnt = g_lvl[0].cnt_v[0];
  assign count    = root_any ? CNT_W'(root_cnt) : CNT_W'(WIDTH);

  always_comb begin
    num_d      = num_q;
    all_zero_d = all_zero_q;
    valid_d    = in_valid;
    if (in_valid) begin
      num_d      = count;
      all_zero_d = ~root_any;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q      <= '0;
      all_zero_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      num_q      <= num_d;
      all_zero_q <= all_zero_d;
      valid_q    <= valid_d;
    end
  end

  assign num       = num_q;
  assign all_zero  = all_zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_clz_counter.sv
// tb/tb_clz_counter.sv - self-checking bench for clz_counter with a behavioural reference model
module tb_clz_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        clo = 1'b0;
  logic [31:0] data = '0;
  logic [5:0]  num;
  logic        all_zero;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int exp_num   = 0;
  int exp_az    = 0;
  int exp_valid = 0;

  clz_counter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .clo       (clo),
    .data      (data),
    .num       (num),
    .all_zero  (all_zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int ref_clz(logic [31:0] d, logic c);
    logic [31:0] v;
    int n;
    v = c ? ~d : d;
    n = 0;
    while (n < 32 && !v[31-n]) n++;
    return n;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_num = 0; exp_az = 0; exp_valid = 0;
    end else begin
      exp_valid = int'(in_valid);
      if (in_valid) begin
        exp_num = ref_clz(data, clo);
        exp_az  = (exp_num == 32) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_num", int'(num), exp_num);
      chk("model_all_zero", int'(all_zero), exp_az);
      chk("model_out_valid", int'(out_valid), exp_valid);
    end
  end

  // Inputs change on the falling edge; after return the outputs reflect this operand.
  task automatic drive(logic v, logic c, logic [31:0] d);
    in_valid = v;
    clo      = c;
    data     = d;
    @(negedge clk);
  endtask

  logic [31:0] ones = 32'hFFFF_FFFF;
  logic [31:0] clo_data [4] = '{32'hFFFF_FFFF, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
  int          clo_exp  [4] = '{32, 16, 0, 31};

  initial begin
    logic [31:0] d;
    logic [31:0] mask;

    chk("ref_pin_a", ref_clz(32'h0001_0000, 1'b0), 15);
    chk("ref_pin_b", ref_clz(32'hF000_0000, 1'b1), 4);

    rst_n = 1'b0;
    in_valid = 1'b1;
    data = '0;
    repeat (3) begin
      @(negedge clk);
      cmp_en = 1'b1;
    end
    chk("reset_num", int'(num), 0);
    chk("reset_all_zero", int'(all_zero), 0);
    chk("reset_out_valid", int'(out_valid), 0);

    rst_n = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      d = ones >> i;
      drive(1'b1, 1'b0, d);
      chk("walk_num", int'(num), i);
      chk("walk_all_zero", int'(all_zero), (i == 32) ? 1 : 0);
      chk("walk_out_valid", int'(out_valid), 1);
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, clo_data[i]);
      chk("clo_num", int'(num), clo_exp[i]);
      chk("clo_all_zero", int'(all_zero), (clo_exp[i] == 32) ? 1 : 0);
    end

    drive(1'b1, 1'b0, 32'h00F0_0000);
    chk("hold_load_num", int'(num), 8);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'($urandom), $urandom);
      chk("hold_num", int'(num), 8);
      chk("hold_out_valid", int'(out_valid), 0);
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i % 2), 32'h0000_FFFF);
      chk("alt_num", int'(num), (i % 2 == 0) ? 16 : 0);
      chk("alt_out_valid", int'(out_valid), 1);
    end

    for (int k = 0; k < 32; k++) begin
      d    = 32'd1 << k;
      mask = d - 32'd1;
      drive(1'b1, 1'b0, d | ($urandom & mask));
      chk("pos_num", int'(num), 31 - k);
      chk("pos_all_zero", int'(all_zero), 0);
    end

    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      d = $urandom;
      d = d >> $urandom_range(0, 32);
      if ($urandom_range(0, 1) == 1) d = ~d;
      drive($urandom_range(0, 7) != 0, 1'($urandom), d);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clz_counter.md
Name: clz_counter

Overview:
- Registered count-leading-zeros / count-leading-ones unit for the 54-instruction single-cycle MIPS CPU datapath.
- Serves the MIPS CLZ and CLO instructions.
- Takes a 32-bit operand and returns the number of consecutive leading 0s (or 1s) counted from bit 31.
- Result is registered with one-cycle latency and a valid strobe.

Parameters:
- WIDTH, 32, operand width. Must be a power of two, 4..64.
- CNT_W, $clog2(WIDTH)+1 (6 for WIDTH=32), count width. Wide enough to hold the value WIDTH.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand qualifier. An operand is accepted on every clk edge where in_valid=1.
- clo  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO).
- data  input  WIDTH  operand.
- num  output  CNT_W  leading-bit count, range 0..WIDTH.
- all_zero  output  1  set when every bit examined was the counted value, i.e. num==WIDTH.
- out_valid  output  1  num/all_zero carry the result of the operand accepted on the previous edge.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, num←0, all_zero←0, out_valid←0. Reset has priority over in_valid. Reset while an operand is being accepted discards that operand.
- Counting is combinational:
  - Form x = clo ? ~data : data.
  - count = index distance from bit WIDTH-1 down to the highest set bit of x.
  - Examples: x[WIDTH-1]=1 → 0; x==1 → WIDTH-1; x==0 → WIDTH.
- Register stage, on each rising edge with rst_n=1:
  - out_valid←in_valid.
  - If in_valid=1: num←count, all_zero←(x==0).
  - If in_valid=0: num and all_zero hold their previous values (out_valid drops to 0).
- Latency: exactly 1 clock. Throughput: 1 operand/clock, back-to-back, no stall or back-pressure.
- clo is sampled together with data under in_valid. Changing clo between operands needs no idle cycle.
- No X propagation permitted: with in_valid=0 the registers hold regardless of data/clo.
- Implementation structure:
  - Balanced tree of 4-bit leading-zero encoders feeding merge nodes, with log2 depth.
  - Each node outputs (valid-any-one, partial count).
  - Priority if/else chains over 32 bits are not to be used.
- Arithmetic: count is unsigned CNT_W bits. A result of WIDTH must not be truncated; for WIDTH=32 the MSB of num is 1 only for 32.

Decomposition:
- Shared package clz_pkg:
  - Constants CLZ_WIDTH=32 and CLZ_CNT_W=6.
  - Mode enum {CLZ_MODE_ZERO=0, CLZ_MODE_ONE=1}.
- One natural sub-module: clz_enc_node.
  - Parameterised merge node.
  - Combines two half-width (any, count) pairs into one full-width pair.
  - Leaf variant handles 4 bits.
  - Instantiated recursively/generate-looped by clz_counter.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with in_valid=1, data=0 → num=0, all_zero=0, out_valid=0. Release: the first accepted operand appears one edge later.
- Walking shift, CLZ: data starts at 0xFFFF_FFFF and is shifted right by 1 each clock with in_valid=1. Required num one cycle later: 0xFFFFFFFF→0, 0x7FFFFFFF→1, 0x0000FFFF→16, 0x00000001→31, 0x00000000→32 with all_zero=1.
- CLO: clo=1.
  - 0xFFFFFFFF → 32, all_zero=1.
  - 0xFFFF0000 → 16.
  - 0x7FFFFFFF → 0.
  - 0xFFFFFFFE → 31.
- Hold: accept 0x00F0_0000 (num=8), then in_valid=0 for 4 clocks while data toggles randomly → num stays 8, out_valid=0.
- Back-to-back mode switching: alternate clo=0/1 each clock on data=0x0000_FFFF → num alternates 16,0,16,0 with out_valid=1 continuously.
- Exhaustive-position check: for every k in 0..31, data=(1<<k)|random lower bits → CLZ num=31-k. Compare against a behavioural reference model over 10k random operands in both modes.
